// File: rtl/jump_target_hazard_ctrl_pkg.sv
// Shared definitions for the jump-target hazard controller.
//   REG_AW     : default register-number width
//   fwd_sel_e  : select codes driven to the jump-target operand mux
//   jt_state_e : controller FSM states
package jump_target_hazard_ctrl_pkg;

  localparam int unsigned REG_AW = 4;

  typedef enum logic [2:0] {
    FWD_NONE    = 3'b000,
    FWD_FAR_LO  = 3'b001,
    FWD_FAR_HI  = 3'b010,
    FWD_NEAR_LO = 3'b011,
    FWD_NEAR_HI = 3'b100
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STALL,
    ST_FLUSH
  } jt_state_e;

endpackage

// File: rtl/jump_target_hazard_ctrl_jt_src_match.sv
// Combinational comparator of the jump source register against the two
// in-flight producer stages.
//   id_rs                          : jump target source register
//   near_wr_en/near_rd/near_hi     : one-stage-away producer
//   near_is_load                   : near producer data not yet available
//   far_wr_en/far_rd/far_hi        : two-stage-away producer
//   near_m / far_m                 : per-stage register match
//   sel                            : candidate forwarding select (near wins)
module jt_src_match
  import jump_target_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW        = jump_target_hazard_ctrl_pkg::REG_AW,
  parameter bit          ZERO_REG_HARD = 1'b1
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic              near_wr_en,
  input  logic [REG_AW-1:0] near_rd,
  input  logic              near_hi,
  input  logic              near_is_load,
  input  logic              far_wr_en,
  input  logic [REG_AW-1:0] far_rd,
  input  logic              far_hi,
  output logic              near_m,
  output logic              far_m,
  output fwd_sel_e          sel
);

  logic w_rs_zero;

  // Register 0 is hardwired zero, so a write to it never produces a hazard.
  assign w_rs_zero = ZERO_REG_HARD && (id_rs == '0);

  assign near_m = near_wr_en && (near_rd == id_rs) && !w_rs_zero;
  assign far_m  = far_wr_en  && (far_rd  == id_rs) && !w_rs_zero;

  // A near load has no data to forward yet, so the far stage may still
  // supply the select; the stall itself is decided by the top.
  always_comb begin
    sel = FWD_NONE;
    if (near_m && !near_is_load) begin
      sel = near_hi ? FWD_NEAR_HI : FWD_NEAR_LO;
    end else if (far_m) begin
      sel = far_hi ? FWD_FAR_HI : FWD_FAR_LO;
    end
  end

endmodule

// File: rtl/jump_target_hazard_ctrl.sv
// Decode-stage controller for jump-register target operands.
//   clk, rst_n       : clock (rising edge), async active-low reset
//   id_jump, id_rs   : decode holds a jump-register and its source register
//   near_* / far_*   : producer info from the two in-flight stages
//   hazard, fwd_sel  : jump-target mux forwarding enable and select
//   stall            : freeze PC and IF/ID, bubble into EX
//   jump_take        : load jump target into PC
//   flush            : squash the instruction fetched behind a taken jump
module jump_target_hazard_ctrl
  import jump_target_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW        = jump_target_hazard_ctrl_pkg::REG_AW,
  parameter int unsigned LOAD_STALL    = 1,
  parameter bit          ZERO_REG_HARD = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_jump,
  input  logic [REG_AW-1:0] id_rs,
  input  logic              near_wr_en,
  input  logic [REG_AW-1:0] near_rd,
  input  logic              near_hi,
  input  logic              near_is_load,
  input  logic              far_wr_en,
  input  logic [REG_AW-1:0] far_rd,
  input  logic              far_hi,
  output logic              hazard,
  output logic [2:0]        fwd_sel,
  output logic              stall,
  output logic              jump_take,
  output logic              flush
);

  localparam int unsigned CNT_W = $clog2(LOAD_STALL) + 1;

  jt_state_e        r_state;
  jt_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic     w_near_m;
  logic     w_far_m;
  fwd_sel_e w_sel;
  logic     w_load_use;

  jt_src_match #(
    .REG_AW        (REG_AW),
    .ZERO_REG_HARD (ZERO_REG_HARD)
  ) u_match (
    .id_rs        (id_rs),
    .near_wr_en   (near_wr_en),
    .near_rd      (near_rd),
    .near_hi      (near_hi),
    .near_is_load (near_is_load),
    .far_wr_en    (far_wr_en),
    .far_rd       (far_rd),
    .far_hi       (far_hi),
    .near_m       (w_near_m),
    .far_m        (w_far_m),
    .sel          (w_sel)
  );

  assign w_load_use = id_jump && w_near_m && near_is_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The detection cycle in IDLE is the first stall cycle, so STALL only
  // covers the remaining LOAD_STALL-1 cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_load_use) begin
          if (LOAD_STALL > 1) begin
            w_state_nxt = ST_STALL;
            w_cnt_nxt   = CNT_W'(LOAD_STALL - 1);
          end
        end else if (id_jump) begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_STALL: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_FLUSH: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are gated by rst_n so they drop asynchronously when reset is
  // asserted, even while the inputs still present a hazard.
  always_comb begin
    hazard    = 1'b0;
    fwd_sel   = FWD_NONE;
    stall     = 1'b0;
    jump_take = 1'b0;
    flush     = 1'b0;
    if (rst_n) begin
      unique case (r_state)
        ST_IDLE: begin
          if (id_jump && (w_sel != FWD_NONE)) begin
            hazard  = 1'b1;
            fwd_sel = w_sel;
          end
          if (w_load_use) begin
            stall = 1'b1;
          end else if (id_jump) begin
            jump_take = 1'b1;
          end
        end
        ST_STALL: begin
          if (id_jump && (w_sel != FWD_NONE)) begin
            hazard  = 1'b1;
            fwd_sel = w_sel;
          end
          stall = 1'b1;
        end
        ST_FLUSH: begin
          flush = 1'b1;
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jump_target_hazard_ctrl.sv
module tb_jump_target_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_jump;
  logic [3:0] id_rs;
  logic       near_wr_en;
  logic [3:0] near_rd;
  logic       near_hi;
  logic       near_is_load;
  logic       far_wr_en;
  logic [3:0] far_rd;
  logic       far_hi;

  logic       hazard_a, stall_a, take_a, flush_a;
  logic [2:0] sel_a;
  logic       hazard_b, stall_b, take_b, flush_b;
  logic [2:0] sel_b;

  int tests = 0;
  int fails = 0;

  // Reference state per DUT: index 0 -> LOAD_STALL=1, index 1 -> LOAD_STALL=3
  int unsigned ls_of[2] = '{1, 3};
  int          m_left[2];
  bit          m_flush[2];

  always #5 clk = ~clk;

  jump_target_hazard_ctrl #(.REG_AW(4), .LOAD_STALL(1), .ZERO_REG_HARD(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_jump(id_jump), .id_rs(id_rs),
    .near_wr_en(near_wr_en), .near_rd(near_rd), .near_hi(near_hi),
    .near_is_load(near_is_load), .far_wr_en(far_wr_en), .far_rd(far_rd),
    .far_hi(far_hi), .hazard(hazard_a), .fwd_sel(sel_a), .stall(stall_a),
    .jump_take(take_a), .flush(flush_a)
  );

  jump_target_hazard_ctrl #(.REG_AW(4), .LOAD_STALL(3), .ZERO_REG_HARD(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_jump(id_jump), .id_rs(id_rs),
    .near_wr_en(near_wr_en), .near_rd(near_rd), .near_hi(near_hi),
    .near_is_load(near_is_load), .far_wr_en(far_wr_en), .far_rd(far_rd),
    .far_hi(far_hi), .hazard(hazard_b), .fwd_sel(sel_b), .stall(stall_b),
    .jump_take(take_b), .flush(flush_b)
  );

  function automatic bit near_match();
    return near_wr_en && (near_rd == id_rs) && (id_rs != 4'd0);
  endfunction

  function automatic bit far_match();
    return far_wr_en && (far_rd == id_rs) && (id_rs != 4'd0);
  endfunction

  function automatic bit load_use();
    return id_jump && near_match() && near_is_load;
  endfunction

  // Expected {hazard, fwd_sel, stall, jump_take, flush}
  function automatic logic [6:0] expected(int k);
    logic       h, st, tk, fl;
    logic [2:0] s;
    h = 0; s = 3'd0; st = 0; tk = 0; fl = 0;
    if (rst_n) begin
      if (m_flush[k]) begin
        fl = 1;
      end else begin
        if (id_jump && near_match() && !near_is_load) begin
          h = 1; s = near_hi ? 3'd4 : 3'd3;
        end else if (id_jump && far_match()) begin
          h = 1; s = far_hi ? 3'd2 : 3'd1;
        end
        if (m_left[k] > 0 || load_use()) st = 1;
        else if (id_jump) tk = 1;
      end
    end
    return {h, s, st, tk, fl};
  endfunction

  task automatic model_advance();
    for (int k = 0; k < 2; k++) begin
      if (m_flush[k]) m_flush[k] = 0;
      else if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
      else if (load_use()) m_left[k] = int'(ls_of[k]) - 1;
      else if (id_jump) m_flush[k] = 1;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k]  = 0;
      m_flush[k] = 0;
    end
  endtask

  task automatic check(input string tag);
    logic [6:0] obs_a, obs_b, exp_a, exp_b;
    obs_a = {hazard_a, sel_a, stall_a, take_a, flush_a};
    obs_b = {hazard_b, sel_b, stall_b, take_b, flush_b};
    exp_a = expected(0);
    exp_b = expected(1);
    tests++;
    assert (obs_a === exp_a) else begin
      fails++;
      $error("FAIL %s ls1 {haz,sel,stall,take,flush} got=%b want=%b", tag, obs_a, exp_a);
    end
    tests++;
    assert (obs_b === exp_b) else begin
      fails++;
      $error("FAIL %s ls3 {haz,sel,stall,take,flush} got=%b want=%b", tag, obs_b, exp_b);
    end
  endtask

  // Called just after a falling edge: settle, compare, advance model, next negedge.
  task automatic tick(input string tag);
    #2;
    check(tag);
    if (rst_n) model_advance();
    @(negedge clk);
  endtask

  // Reset pulse inside the current cycle, released before the next rising edge.
  task automatic tick_with_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, "_in_rst"});
    rst_n = 1'b1;
    #1;
    check({tag, "_released"});
    model_advance();
    @(negedge clk);
  endtask

  task automatic drive(input logic j, input logic [3:0] rs,
                       input logic nwe, input logic [3:0] nrd, input logic nhi, input logic nld,
                       input logic fwe, input logic [3:0] frd, input logic fhi);
    id_jump = j; id_rs = rs;
    near_wr_en = nwe; near_rd = nrd; near_hi = nhi; near_is_load = nld;
    far_wr_en = fwe; far_rd = frd; far_hi = fhi;
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    drive(1, 4'd5, 0, 4'd0, 0, 0, 0, 4'd0, 0);
    @(negedge clk);
    tick("reset_hold");
    rst_n = 1'b1;

    // Plain jump, then flush, then quiet
    drive(1, 4'd5, 0, 4'd0, 0, 0, 0, 4'd0, 0);
    tick("plain_take");
    drive(0, 4'd0, 0, 4'd0, 0, 0, 0, 4'd0, 0);
    tick("plain_flush");
    tick("plain_idle");

    // Both stages match: near wins
    drive(1, 4'd3, 1, 4'd3, 1, 0, 1, 4'd3, 0);
    tick("near_priority");
    drive(0, 4'd0, 0, 4'd0, 0, 0, 0, 4'd0, 0);
    tick("near_flush");

    // Far-only forward, then register 0 never matches
    drive(1, 4'd7, 0, 4'd0, 0, 0, 1, 4'd7, 0);
    tick("far_lo");
    drive(0, 4'd0, 0, 4'd0, 0, 0, 0, 4'd0, 0);
    tick("far_flush");
    drive(1, 4'd0, 1, 4'd0, 0, 0, 1, 4'd0, 0);
    tick("zero_reg");
    drive(0, 4'd0, 0, 4'd0, 0, 0, 0, 4'd0, 0);
    tick("zero_flush");

    // Back-to-back jumps: second is squashed by the flush
    drive(1, 4'd9, 0, 4'd0, 0, 0, 0, 4'd0, 0);
    tick("b2b_first");
    tick("b2b_squashed");
    drive(0, 4'd0, 0, 4'd0, 0, 0, 0, 4'd0, 0);
    tick("b2b_idle");

    // Load-use: 1-cycle vs 3-cycle stall, load then moves to far
    drive(1, 4'd2, 1, 4'd2, 0, 1, 0, 4'd0, 0);
    tick("lu_detect");
    drive(1, 4'd2, 0, 4'd0, 0, 0, 1, 4'd2, 0);
    tick("lu_cyc2");
    tick("lu_cyc3");
    tick("lu_cyc4");
    drive(0, 4'd0, 0, 4'd0, 0, 0, 0, 4'd0, 0);
    tick("lu_cyc5");
    tick("lu_cyc6");

    // Reset during the second stall cycle of the 3-cycle controller
    drive(1, 4'd2, 1, 4'd2, 1, 1, 0, 4'd0, 0);
    tick("rst_stall1");
    tick_with_reset("rst_stall2");
    drive(1, 4'd2, 0, 4'd0, 0, 0, 1, 4'd2, 1);
    tick("rst_after1");
    tick("rst_after2");
    tick("rst_after3");
    drive(0, 4'd0, 0, 4'd0, 0, 0, 0, 4'd0, 0);
    tick("rst_after4");
    tick("rst_after5");

    // Randomized traffic on a narrow register range to provoke matches
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 39) == 0) tick_with_reset("rand_rst");
      else tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
